// File: rtl/alu_share_ctrl.sv
// Shares one combinational myALU between two valid/ready requesters.
// Round-robin grant in IDLE, operands evaluated in EXEC, tagged result held in RESP.

module myALU #(
    parameter int W = 16
) (
    input  logic [2:0]   opc,
    input  logic [W-1:0] m,
    input  logic [W-1:0] n,
    input  logic         c,
    output logic [W-1:0] f,
    output logic         zer,
    output logic         neg
);
    logic signed [W-1:0] ms;
    logic signed [W-1:0] ns;

    always_comb begin
        ms = $signed(m);
        ns = $signed(n);
        f  = '0;
        case (opc)
            3'b000:  f = m + n + {{(W-1){1'b0}}, c};
            3'b001:  f = ms + (ns >>> 1);
            3'b010:  f = m + {{(W-1){1'b0}}, 1'b1};
            3'b011:  f = ms + (ms >>> 1);
            3'b100:  f = m & n;
            3'b101:  f = m | n;
            3'b110:  f = ~m;
            default: f = '0;
        endcase
        zer = (f == '0);
        neg = f[W-1];
    end
endmodule

module alu_share_ctrl #(
    parameter int W     = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [2:0]       a_opc,
    input  logic [W-1:0]     a_m,
    input  logic [W-1:0]     a_n,
    input  logic             a_c,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [2:0]       b_opc,
    input  logic [W-1:0]     b_m,
    input  logic [W-1:0]     b_n,
    input  logic             b_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [W-1:0]     rsp_f,
    output logic             rsp_zer,
    output logic             rsp_neg,
    output logic             busy,
    output logic [CNT_W-1:0] a_grants,
    output logic [CNT_W-1:0] b_grants
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_reg;
    logic           last_grant_reg;   // 0 = A, 1 = B
    logic           id_reg;
    logic [2:0]     opc_reg;
    logic [W-1:0]   m_reg;
    logic [W-1:0]   n_reg;
    logic           c_reg;
    logic           rsp_valid_reg;
    logic           rsp_id_reg;
    logic [W-1:0]   rsp_f_reg;
    logic           rsp_zer_reg;
    logic           rsp_neg_reg;

    logic           grant_a;
    logic           grant_b;
    logic [1:0]     grant_vec;
    logic [W-1:0]   alu_f;
    logic           alu_zer;
    logic           alu_neg;

    // On a tie the requester not granted last wins; grants are suppressed during reset.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst && state_reg == IDLE) begin
            if (a_valid && (!b_valid || last_grant_reg))
                grant_a = 1'b1;
            else if (b_valid)
                grant_b = 1'b1;
        end
    end

    assign grant_vec = {grant_b, grant_a};
    assign a_ready   = grant_a;
    assign b_ready   = grant_b;

    myALU #(.W(W)) u_alu (
        .opc (opc_reg),
        .m   (m_reg),
        .n   (n_reg),
        .c   (c_reg),
        .f   (alu_f),
        .zer (alu_zer),
        .neg (alu_neg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            id_reg         <= 1'b0;
            opc_reg        <= '0;
            m_reg          <= '0;
            n_reg          <= '0;
            c_reg          <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_f_reg      <= '0;
            rsp_zer_reg    <= 1'b0;
            rsp_neg_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        opc_reg        <= grant_b ? b_opc : a_opc;
                        m_reg          <= grant_b ? b_m   : a_m;
                        n_reg          <= grant_b ? b_n   : a_n;
                        c_reg          <= grant_b ? b_c   : a_c;
                        id_reg         <= grant_b;
                        last_grant_reg <= grant_b;
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_f_reg     <= alu_f;
                    rsp_zer_reg   <= alu_zer;
                    rsp_neg_reg   <= alu_neg;
                    rsp_id_reg    <= id_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // One wrapping grant counter per requester, indexed 0 = A, 1 = B.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (rst)
                cnt_reg <= '0;
            else if (grant_vec[gi])
                cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign a_grants  = g_cnt[0].cnt_reg;
    assign b_grants  = g_cnt[1].cnt_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_f     = rsp_f_reg;
    assign rsp_zer   = rsp_zer_reg;
    assign rsp_neg   = rsp_neg_reg;
    assign busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: expected responses are queued at grant
// time from an independent ALU model and compared when the response handshakes.

module tb_alu_share_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [2:0]  a_opc = '0, b_opc = '0;
    logic [15:0] a_m = '0, a_n = '0, b_m = '0, b_n = '0;
    logic        a_c = 1'b0, b_c = 1'b0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic        rsp_id, rsp_zer, rsp_neg, busy;
    logic [15:0] rsp_f;
    logic [7:0]  a_grants, b_grants;

    typedef struct packed {
        logic        id;
        logic [15:0] f;
        logic        zer;
        logic        neg;
    } rsp_t;

    rsp_t q[$];
    int   errors = 0;
    int   checks = 0;

    alu_share_ctrl #(.W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_opc(a_opc), .a_m(a_m), .a_n(a_n), .a_c(a_c),
        .b_valid(b_valid), .b_ready(b_ready), .b_opc(b_opc), .b_m(b_m), .b_n(b_n), .b_c(b_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_f(rsp_f),
        .rsp_zer(rsp_zer), .rsp_neg(rsp_neg), .busy(busy),
        .a_grants(a_grants), .b_grants(b_grants)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] alu_model(input logic [2:0] opc, input logic [15:0] m,
                                              input logic [15:0] n, input logic c);
        case (opc)
            3'd0:    return m + n + {15'd0, c};
            3'd1:    return m + {n[15], n[15:1]};
            3'd2:    return m + 16'd1;
            3'd3:    return m + {m[15], m[15:1]};
            3'd4:    return m & n;
            3'd5:    return m | n;
            3'd6:    return ~m;
            default: return 16'd0;
        endcase
    endfunction

    function automatic rsp_t mk_exp(input logic id, input logic [2:0] opc, input logic [15:0] m,
                                    input logic [15:0] n, input logic c);
        rsp_t r;
        r.id  = id;
        r.f   = alu_model(opc, m, n, c);
        r.zer = (r.f == 16'd0);
        r.neg = r.f[15];
        return r;
    endfunction

    // Response monitor: pops and compares on every completed response handshake.
    always @(negedge clk) begin
        if (a_ready || b_ready)
            check_eq("ready_excl", {31'd0, a_ready & b_ready}, 32'd0);
        if (!rst && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                check_eq("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = q.pop_front();
                $display("rsp id=%0d f=%h zer=%0d neg=%0d (exp id=%0d f=%h)",
                         rsp_id, rsp_f, rsp_zer, rsp_neg, e.id, e.f);
                check_eq("rsp_id",  {31'd0, rsp_id},  {31'd0, e.id});
                check_eq("rsp_f",   {16'd0, rsp_f},   {16'd0, e.f});
                check_eq("rsp_zer", {31'd0, rsp_zer}, {31'd0, e.zer});
                check_eq("rsp_neg", {31'd0, rsp_neg}, {31'd0, e.neg});
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
    endtask

    // Presents one operation, waits for its ready, then drops valid right after the handshake.
    task automatic do_req(input logic s, input logic [2:0] opc, input logic [15:0] m,
                          input logic [15:0] n, input logic c, input bit expect_rsp);
        bit got = 0;
        @(posedge clk); #1;
        if (!s) begin a_valid = 1; a_opc = opc; a_m = m; a_n = n; a_c = c; end
        else    begin b_valid = 1; b_opc = opc; b_m = m; b_n = n; b_c = c; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (s ? b_ready : a_ready) begin
                got = 1;
                if (expect_rsp) q.push_back(mk_exp(s, opc, m, n, c));
            end
        end
        check_eq("grant_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        if (!s) a_valid = 0; else b_valid = 0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) done = 1;
        end
        check_eq("drain", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int   ngr, last_cyc, cyc;
        logic turn, id;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy",  {31'd0, busy},      32'd0);
        check_eq("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_ready", {30'd0, a_ready, b_ready}, 32'd0);
        check_eq("rst_rsp",   {13'd0, rsp_id, rsp_f, rsp_zer, rsp_neg}, 32'd0);
        check_eq("rst_cnt",   {16'd0, a_grants, b_grants}, 32'd0);
        #1 rst = 1'b0;

        // A only, opc 000: latency and initial counter
        rsp_ready = 0;
        do_req(0, 3'd0, 16'h0005, 16'h0003, 1'b1, 1);
        @(negedge clk);
        check_eq("t1_busy",    {31'd0, busy},      32'd1);
        check_eq("t1_early",   {31'd0, rsp_valid}, 32'd0);
        check_eq("t1_ready",   {31'd0, a_ready},   32'd0);
        check_eq("t1_agrants", {24'd0, a_grants},  32'd1);
        @(negedge clk);
        check_eq("t1_valid",   {31'd0, rsp_valid}, 32'd1);
        check_eq("t1_f",       {16'd0, rsp_f},     32'h0009);
        @(posedge clk); #1 rsp_ready = 1;
        wait_drain();

        // B-only sequence
        do_req(1, 3'd1, 16'h0010, 16'hFFFC, 1'b0, 1);
        wait_drain();
        do_req(1, 3'd2, 16'h7FFF, 16'h0000, 1'b0, 1);
        wait_drain();
        do_req(1, 3'd6, 16'hFFFF, 16'h0000, 1'b0, 1);
        wait_drain();
        check_eq("b_grants3", {24'd0, b_grants}, 32'd3);

        // Back-pressure: A stays pending while the response is held
        rsp_ready = 0;
        do_req(0, 3'd4, 16'hF0F0, 16'h0FF0, 1'b0, 1);
        a_valid = 1; a_opc = 3'd5; a_m = 16'h1200; a_n = 16'h0034; a_c = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("bp_f",     {16'd0, rsp_f},     32'h00F0);
            check_eq("bp_ready", {31'd0, a_ready},   32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1;
        @(negedge clk);
        check_eq("bp_hs_ready", {31'd0, a_ready}, 32'd0);
        @(negedge clk);
        check_eq("bp_regrant", {31'd0, a_ready}, 32'd1);
        if (a_ready) q.push_back(mk_exp(0, a_opc, a_m, a_n, a_c));
        @(posedge clk); #1 a_valid = 0;
        wait_drain();

        // Reset in EXEC discards the operation
        do_req(0, 3'd0, 16'h0001, 16'h0001, 1'b0, 0);
        rst = 1;
        @(negedge clk);
        check_eq("rx_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check_eq("rx_busy",  {31'd0, busy},      32'd0);
        check_eq("rx_valid2", {31'd0, rsp_valid}, 32'd0);
        check_eq("rx_rsp",   {13'd0, rsp_id, rsp_f, rsp_zer, rsp_neg}, 32'd0);
        check_eq("rx_cnt",   {16'd0, a_grants, b_grants}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check_eq("rx_norsp", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        a_valid = 1; a_opc = 3'd3; a_m = 16'h0100; a_n = 16'h0000; a_c = 0;
        b_valid = 1; b_opc = 3'd7; b_m = 16'h1111; b_n = 16'h2222; b_c = 0;
        @(negedge clk);
        check_eq("rx_tie_a", {30'd0, a_ready, b_ready}, 32'd2);
        if (a_ready) q.push_back(mk_exp(0, a_opc, a_m, a_n, a_c));
        @(posedge clk); #1 a_valid = 0; b_valid = 0;
        wait_drain();

        // Both requesters continuously valid from reset
        do_reset();
        rsp_ready = 1;
        a_valid = 1; a_opc = 3'd0; a_m = 16'h8000; a_n = 16'h8000; a_c = 0;
        b_valid = 1; b_opc = 3'd3; b_m = 16'hC000; b_n = 16'h0000; b_c = 0;
        ngr = 0; last_cyc = 0; turn = 0;
        for (cyc = 0; cyc < 60 && ngr < 8; cyc++) begin
            @(negedge clk);
            if (a_ready || b_ready) begin
                id = b_ready;
                check_eq("rr_order", {31'd0, id}, {31'd0, turn});
                if (ngr > 0) check_eq("rr_gap", cyc - last_cyc, 32'd3);
                if (!id) q.push_back(mk_exp(0, a_opc, a_m, a_n, a_c));
                else     q.push_back(mk_exp(1, b_opc, b_m, b_n, b_c));
                turn = ~turn; last_cyc = cyc; ngr++;
                @(posedge clk); #1;
                if (!id) begin
                    a_opc = 3'($urandom_range(0, 7)); a_m = 16'($urandom); a_n = 16'($urandom); a_c = 1'($urandom);
                end else begin
                    b_opc = 3'($urandom_range(0, 7)); b_m = 16'($urandom); b_n = 16'($urandom); b_c = 1'($urandom);
                end
            end
        end
        check_eq("rr_count", ngr, 32'd8);
        a_valid = 0; b_valid = 0;
        wait_drain();

        // Counter wrap
        do_reset();
        do_req(1, 3'd5, 16'h00FF, 16'hFF00, 1'b0, 1);
        wait_drain();
        for (int i = 0; i < 255; i++)
            do_req(0, 3'd2, 16'(i), 16'h0000, 1'b0, 1);
        wait_drain();
        check_eq("wrap_255", {24'd0, a_grants}, 32'd255);
        do_req(0, 3'd0, 16'hFFFF, 16'h0000, 1'b1, 1);
        wait_drain();
        check_eq("wrap_0",    {24'd0, a_grants}, 32'd0);
        check_eq("wrap_bcnt", {24'd0, b_grants}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
